// File: rtl/inst_loader.sv
// inst_loader: boot loader turning a SYNC/CNT/data byte stream into 32-bit instruction memory writes
//   clk, rstn            clock, asynchronous active-low reset
//   in_data/valid/ready  byte stream handshake from the host link
//   mem_we/addr/wdata    instruction memory write port, one strobe per assembled word
//   core_hold            stalls fetch while a load is in progress
//   load_done, load_err  completion pulse, sticky bad-count flag
module inst_loader #(
    parameter int         DEPTH = 128,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err
);
    localparam int IW = $clog2(DEPTH) + 1;
    typedef enum logic [2:0] {IDLE, CNT0, CNT1, DATA, WRITE, DONE, ERR} state_t;
    state_t        state;
    logic [15:0]   cnt;
    logic [IW-1:0] idx;
    logic [1:0]    bidx;
    logic [23:0]   word;
    logic          fire;
    logic [15:0]   cnt_full;
    logic [15:0]   idx_next;
    assign fire     = in_valid & in_ready;
    assign cnt_full = {in_data, cnt[7:0]};
    assign idx_next = 16'(idx) + 16'd1;
    // Outputs are set on the transition into the state they belong to, so they
    // are registered yet line up with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            bidx      <= '0;
            word      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_hold <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (fire && in_data == SYNC) begin
                        load_err  <= 1'b0;
                        core_hold <= 1'b1;
                        state     <= CNT0;
                    end
                end
                CNT0: if (fire) begin
                    cnt[7:0] <= in_data;
                    state    <= CNT1;
                end
                CNT1: if (fire) begin
                    cnt[15:8] <= in_data;
                    if (cnt_full == 16'd0) begin
                        in_ready  <= 1'b0;
                        core_hold <= 1'b0;
                        load_done <= 1'b1;
                        state     <= DONE;
                    end else if (cnt_full > 16'(DEPTH)) begin
                        in_ready  <= 1'b0;
                        core_hold <= 1'b0;
                        load_err  <= 1'b1;
                        state     <= ERR;
                    end else begin
                        idx   <= '0;
                        bidx  <= '0;
                        state <= DATA;
                    end
                end
                DATA: if (fire) begin
                    // little-endian: bytes shift in from the top, first byte ends lowest
                    word <= {in_data, word[23:8]};
                    bidx <= bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= 32'({idx, 2'b00});
                        mem_wdata <= {in_data, word};
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    idx <= idx + 1'b1;
                    if (idx_next == cnt) begin
                        core_hold <= 1'b0;
                        load_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        bidx     <= '0;
                        in_ready <= 1'b1;
                        state    <= DATA;
                    end
                end
                DONE, ERR: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: scoreboard bench for inst_loader
module tb_inst_loader;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    logic [63:0] sb[$];

    inst_loader dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // write monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin
        if (rstn) begin
            if (core_hold) check("ready_vs_write", {31'd0, in_ready}, {31'd0, !mem_we});
            if (mem_we) begin
                n_wr++;
                check("hold_in_write", {31'd0, core_hold}, 32'd1);
                if (sb.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    check("wr_addr", mem_addr, e[63:32]);
                    check("wr_data", mem_wdata, e[31:0]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int b = 0; b < 4; b++) send(w[8*b +: 8], $urandom_range(0, maxgap));
    endtask

    // after the last data byte: WRITE cycle, then DONE cycle
    task automatic expect_done;
        @(negedge clk);
        check("last_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        check("done_pulse", {31'd0, load_done}, 32'd1);
        check("hold_drop", {31'd0, core_hold}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, load_done}, 32'd0);
    endtask

    task automatic load(input int n, input int maxgap);
        logic [31:0] w;
        logic [15:0] c;
        c = 16'(n);
        send(8'hA5, 0);
        send(c[7:0], $urandom_range(0, maxgap));
        send(c[15:8], $urandom_range(0, maxgap));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            sb.push_back({32'(i * 4), w});
            send_word(w, maxgap);
        end
        expect_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_hold"}, {31'd0, core_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_err"}, {31'd0, load_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // two-word frame from fixed bytes
        sb.push_back({32'h0, 32'h00000013});
        sb.push_back({32'h4, 32'h00100093});
        send(8'hA5, 0);
        @(negedge clk);
        check("hold_after_sync", {31'd0, core_hold}, 32'd1);
        send(8'h02, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
        expect_done();
        check("writes_a", n_wr, 32'd2);

        // junk then empty frame
        send(8'h00, 0); send(8'hFF, 0);
        @(negedge clk);
        check("junk_no_hold", {31'd0, core_hold}, 32'd0);
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
        @(negedge clk);
        check("cnt0_done", {31'd0, load_done}, 32'd1);
        check("cnt0_hold", {31'd0, core_hold}, 32'd0);
        check("cnt0_no_write", n_wr, 32'd2);

        // oversize count
        send(8'hA5, 0); send(8'h81, 0); send(8'h00, 0);
        @(negedge clk);
        check("err_set", {31'd0, load_err}, 32'd1);
        check("err_hold", {31'd0, core_hold}, 32'd0);
        check("err_no_done", {31'd0, load_done}, 32'd0);
        repeat (4) @(negedge clk);
        check("err_sticky", {31'd0, load_err}, 32'd1);
        check("err_no_write", n_wr, 32'd2);
        send(8'hA5, 0);
        @(negedge clk);
        check("err_cleared", {31'd0, load_err}, 32'd0);
        send(8'h00, 0); send(8'h00, 0);
        @(negedge clk);
        check("err_then_done", {31'd0, load_done}, 32'd1);

        // full memory
        load(128, 0);
        check("full_writes", n_wr, 32'd130);
        check("full_last_addr", mem_addr, 32'h1FC);
        check("full_no_err", {31'd0, load_err}, 32'd0);

        // three words with random gaps
        load(3, 3);
        check("gap_writes", n_wr, 32'd133);

        // reset mid-word
        w0 = n_wr;
        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
        send(8'h11, 1); send(8'h22, 0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        check("rst_no_write", n_wr, w0);
        rstn = 1'b1;
        load(1, 1);
        check("post_rst_addr", mem_addr, 32'h0);
        check("post_rst_writes", n_wr, w0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that writes into the L1 instruction memory. It accepts a byte stream from a host link (for example a UART receiver) over a valid/ready handshake. It assembles little-endian 32-bit instruction words and issues one write per word into the instruction memory's write port. While a load is in progress it holds the core so that fetch does not race the writes.

## Interface
Parameters:
- DEPTH, 128, instruction memory size in 32-bit words; the largest legal word count.
- SYNC, 8'hA5, start-of-frame byte.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; a byte transfers when in_valid and in_ready are both 1 on a clock edge.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_addr  output  32  byte address of the write, word aligned (bits [1:0] = 0).
- mem_wdata  output  32  instruction word to write.
- core_hold  output  1  stalls fetch and steers the memory address mux to mem_addr. The integration also forces pcwrite high whenever mem_we is 1.
- load_done  output  1  one-cycle pulse when a load completes successfully.
- load_err  output  1  sticky error flag; cleared when the next SYNC byte is accepted.

## Operation
- Frame format: SYNC, CNT_LO, CNT_HI, then CNT×4 data bytes. CNT is a 16-bit word count. Data is little-endian per word: the first byte goes to [7:0].
- States:
  - IDLE: in_ready=1. A non-SYNC byte is discarded. Accepting SYNC clears load_err, sets core_hold=1 and moves to CNT0.
  - CNT0: accept a byte into cnt[7:0], then move to CNT1.
  - CNT1: accept a byte into cnt[15:8].
    - If cnt==0, move to DONE.
    - If cnt>DEPTH, move to ERR.
    - Otherwise clear the word index and byte index and move to DATA.
  - DATA: accept bytes into the shift register at byte index 0..3. On acceptance of byte 3, move to WRITE.
  - WRITE: in_ready=0.
    - mem_we=1, mem_addr={idx,2'b00} zero-extended, mem_wdata=assembled word.
    - Then increment idx. If idx+1==cnt, move to DONE; otherwise return to DATA with byte index 0.
  - DONE: load_done=1 and core_hold=0 for this one cycle, in_ready=0, then move to IDLE.
  - ERR: load_err=1 (sticky), core_hold=0, in_ready=0, then move to IDLE.
- cnt is 16 bits and idx is log2(DEPTH)+1 bits. The comparison against DEPTH is unsigned, and cnt==DEPTH is legal.
- Data bytes beyond the frame length are treated as IDLE traffic and discarded unless they equal SYNC.
- in_valid deasserted mid-frame: the loader waits indefinitely in the current state. There is no timeout.

## Timing
- Reset values:
  - in_ready=0 while rstn=0, and 1 from the first cycle in IDLE after release.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - core_hold=0, load_done=0, load_err=0.
  - State=IDLE.
- All outputs are registered or decoded from the state register. There are no combinational paths from in_data or in_valid to the outputs.
- core_hold rises in the cycle after SYNC is accepted. It stays high through the last WRITE and falls in the DONE or ERR cycle.
- Write latency: mem_we is asserted in the cycle after the 4th byte of a word is accepted, for exactly one cycle. mem_addr and mem_wdata are stable during that cycle.
- Maximum throughput is one word per 5 cycles: 4 accept cycles plus 1 WRITE bubble.
- load_done is asserted one cycle after the final WRITE. For cnt==0, it is asserted one cycle after the CNT_HI byte is accepted.
- Reset asserted mid-frame clears all state immediately and asynchronously; core_hold drops without a clock. Memory words already written keep their values, and no partial word is written.
- mem_we is never asserted in IDLE, CNT0, CNT1, DONE or ERR.

## Test plan
- Frame A5 02 00 13 00 00 00 93 00 10 00 -> two writes: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. load_done pulses once, and core_hold is high from the cycle after A5 through the second write.
- Bytes 00 FF then A5 00 00 -> 00 and FF are discarded. No write occurs, and load_done pulses one cycle after the final 00.
- Frame A5 81 00 (CNT=129 > DEPTH=128) -> load_err=1, no mem_we, core_hold low afterwards. A following A5 clears load_err.
- Frame with CNT=128 -> 128 writes; the last write is at addr 0x1FC. load_err stays 0.
- Random in_valid gaps inside a 3-word frame -> the same three writes as with a gap-free stream, in_ready=0 exactly in the WRITE cycles, and no lost or duplicated bytes.
- rstn pulled low after 2 of 4 bytes of word 1 -> all outputs return to their reset values at once and no write is issued. A fresh frame after reset loads correctly from addr 0.
